// File: rtl/shift_restore.sv
`default_nettype none
// ============================================================================
// shift_restore : bit-serial inverse of the shift/rotate stage (one bit/clk).
// Optional: SHIFT_RESTORE_FILL_EN selects restoring lost bits from in_fill.
// Revision: 1.0
// ============================================================================
module shift_restore #(
    parameter int WIDTH = 4,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_fill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_work;
    logic [1:0]       r_mode;
    logic [AMT_W-1:0] r_cnt;
    logic             w_ins;

`ifdef SHIFT_RESTORE_FILL_EN
    // Fill is consumed LSB-first, so shifting it down keeps the current bit at [0].
    logic [WIDTH-1:0] r_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_fill <= in_fill;
        end else if (r_state == RUN) begin
            r_fill <= r_fill >> 1;
        end
    end

    assign w_ins = r_fill[0];
`else
    logic w_unused_fill;
    assign w_unused_fill = ^in_fill;
    assign w_ins         = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = (in_mode == 2'b00 || in_amt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_mode  <= 2'b00;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= in_data;
                        r_mode <= in_mode;
                        r_cnt  <= in_amt;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - AMT_W'(1);
                    case (r_mode)
                        2'b01:   r_work <= {w_ins, r_work[WIDTH-1:1]};
                        2'b10:   r_work <= {r_work[WIDTH-2:0], w_ins};
                        2'b11:   r_work <= {r_work[WIDTH-2:0], r_work[WIDTH-1]};
                        default: r_work <= r_work;
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_work;
    assign out_mode  = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_shift_restore.sv
`default_nettype none
// ============================================================================
// tb_shift_restore : scoreboard bench with directed and random requests.
// Revision: 1.0
// ============================================================================
module tb_shift_restore;

    localparam int WIDTH = 4;
    localparam int AMT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic [AMT_W-1:0] in_amt;
    logic [WIDTH-1:0] in_fill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_mode;

    shift_restore #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
        .in_fill   (in_fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       mode;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   ready_pct = 100;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Original word rebuilt directly from the transform definitions.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic [1:0] m,
                                               input int k, input logic [WIDTH-1:0] f);
        int dd   = int'(d);
        int ff   = 0;
        int mask = (1 << k) - 1;
        int r    = 0;
`ifdef SHIFT_RESTORE_FILL_EN
        ff = int'(f);
`else
        ff = 0 & int'(f);
`endif
        case (m)
            2'b01: r = (dd >> k) | ((ff & mask) << (WIDTH - k));
            2'b10: begin
                for (int j = 0; j < k; j++) r |= ((ff >> j) & 1) << (k - 1 - j);
                r = r | (dd << k);
            end
            2'b11: r = (dd << k) | (dd >> (WIDTH - k));
            default: r = dd;
        endcase
        return WIDTH'(r & ((1 << WIDTH) - 1));
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: handshake rule, result data/mode, and first-valid latency.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", int'(in_ready), int'(sb.size() == 0));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        check("latency", cyc, sb[0].due);
                        seen = 1'b1;
                    end
                    check("out_data", int'(out_data), int'(sb[0].data));
                    check("out_mode", int'(out_mode), int'(sb[0].mode));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] m,
                        input int k, input logic [WIDTH-1:0] f);
        exp_t e;
        int   n;
        int   waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_amt   = AMT_W'(k);
        in_fill  = f;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                $display("FAIL accept_timeout: got no in_ready expected in_ready within 100 cycles");
                miscompares++;
                $fatal(1, "accept timeout");
            end
        end
        n = cyc;
        e.data = model(d, m, k, f);
        e.mode = m;
        e.due  = n + 1 + ((m == 2'b00) ? 0 : k);
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic drain();
        int waited = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_mode  = 2'b00;
        in_amt   = '0;
        in_fill  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_mode", int'(out_mode), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        send(4'b0110, 2'b01, 1, 4'b0001); drain();
        send(4'b0101, 2'b10, 1, 4'b0001); drain();
        send(4'b0010, 2'b10, 2, 4'b0010); drain();
        send(4'b1101, 2'b11, 3, 4'b1111); drain();
        send(4'b1101, 2'b11, 3, 4'b0000); drain();
        send(4'b1011, 2'b01, 3, 4'b1010); drain();

        // Pass-through held under backpressure, then released.
        ready_pct = 0;
        send(4'b1010, 2'b00, 3, 4'b0110);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        ready_pct = 100;
        drain();

        // Reset after the first RUN step discards the in-flight result.
        send(4'b1001, 2'b11, 3, 4'b0000);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        seen = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        check("midrun_rst_out_valid", int'(out_valid), 0);
        check("midrun_rst_out_data", int'(out_data), 0);
        check("midrun_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send(4'b0001, 2'b11, 1, 4'b0000); drain();

        // Random back-to-back traffic with in_valid held high.
        ready_pct = 60;
        for (int i = 0; i < 150; i++) begin
            send(WIDTH'($urandom), 2'($urandom), int'($urandom_range(WIDTH - 1)), WIDTH'($urandom));
        end
        drain();
        ready_pct = 100;
        for (int i = 0; i < 60; i++) begin
            send(WIDTH'($urandom), 2'($urandom), int'($urandom_range(WIDTH - 1)), WIDTH'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
